// File: rtl/rgb2hsv_pkg.sv
// Shared types and constants for the RGB to HSV stream converter.
// Saturation normalisation is built only with RGB2HSV_SAT_NORM_EN.
package rgb2hsv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SORT,
    DIV_H,
    DIV_S,
    HUE,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    SEC_R,
    SEC_G,
    SEC_B
  } sec_e;

  localparam int HUE_60  = 60;
  localparam int HUE_120 = 120;
  localparam int HUE_240 = 240;
  localparam int HUE_360 = 360;

endpackage

// File: rtl/rgb2hsv_stream_seq_divider.sv
// Restoring bit-serial divider, one quotient bit per cycle.
// quot carries the final quotient during the cycle done is high.
module seq_divider
  import rgb2hsv_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic [DIV_W-1:0] numer,
  input  logic [DIV_W-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quot
);

  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_W - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] qn_q, qn_d;
  logic [DIV_W-1:0] den_q, den_d;
  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   diff;
  logic             ge;
  logic [DIV_W-1:0] qn_it;
  logic             unused_div;

  // One restoring step per cycle; start reloads even mid-run.
  always_comb begin
    trial  = {rem_q, qn_q[DIV_W-1]};
    diff   = trial - {1'b0, den_q};
    ge     = trial >= {1'b0, den_q};
    qn_it  = {qn_q[DIV_W-2:0], ge};
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    qn_d   = qn_q;
    den_d  = den_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      qn_d   = numer;
      den_d  = denom;
    end else if (busy_q) begin
      rem_d = ge ? diff[DIV_W-1:0]
                 : trial[DIV_W-1:0];
      qn_d  = qn_it;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      qn_q   <= '0;
      den_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      qn_q   <= qn_d;
      den_q  <= den_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign quot = qn_it;

  assign unused_div = diff[DIV_W];

endmodule

// File: rtl/rgb2hsv_stream.sv
// Streaming RGB to HSV converter, one pixel in flight at a time.
// Define RGB2HSV_SAT_NORM_EN for normalised saturation.
module rgb2hsv_stream
  import rgb2hsv_pkg::*;
#(
  parameter int CW    = 5,
  parameter int HUE_W = 9
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*CW-1:0]   in_rgb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HUE_W-1:0]  hue,
  output logic [CW-1:0]     saturation,
  output logic [CW-1:0]     value,
  output logic              hue_invalid
);

  localparam int DIV_W = 2 * CW + 6;
  localparam int HW1   = HUE_W + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     r_q, r_d;
  logic [CW-1:0]     g_q, g_d;
  logic [CW-1:0]     b_q, b_d;
  logic [CW-1:0]     max_q, max_d;
  logic [CW-1:0]     c_q, c_d;
  sec_e              sec_q, sec_d;
  logic              neg_q, neg_d;
  logic              hinv_q, hinv_d;
  logic [HUE_W-1:0]  qh_q, qh_d;
  logic [HUE_W-1:0]  hue_q, hue_d;
  logic [CW-1:0]     sat_q, sat_d;
  logic [CW-1:0]     val_q, val_d;
  logic              hio_q, hio_d;
  logic              ov_q, ov_d;
  logic              ir_q, ir_d;
`ifdef RGB2HSV_SAT_NORM_EN
  logic [CW-1:0]     qs_q, qs_d;
`endif

  logic              div_start;
  logic [DIV_W-1:0]  div_numer;
  logic [DIV_W-1:0]  div_denom;
  logic              div_busy;
  logic              div_done;
  logic [DIV_W-1:0]  div_quot;

  logic [CW-1:0]     mx, mn;
  sec_e              sec;
  logic              r_max, g_max;
  logic [CW:0]       d_s, d_m;
  logic [HW1-1:0]    base_w, q_w, h_w;
  logic              unused_top;

  seq_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .res_n(res_n),
    .start(div_start),
    .numer(div_numer),
    .denom(div_denom),
    .busy (div_busy),
    .done (div_done),
    .quot (div_quot)
  );

  // Max/min and hue sector of the latched pixel, ties go R>G>B.
  always_comb begin
    r_max = (r_q >= g_q) && (r_q >= b_q);
    g_max = !r_max && (g_q >= b_q);
    mx    = b_q;
    sec   = SEC_B;
    d_s   = {1'b0, r_q} - {1'b0, g_q};
    unique case (1'b1)
      r_max: begin
        mx  = r_q;
        sec = SEC_R;
        d_s = {1'b0, g_q} - {1'b0, b_q};
      end
      g_max: begin
        mx  = g_q;
        sec = SEC_G;
        d_s = {1'b0, b_q} - {1'b0, r_q};
      end
      default: ;
    endcase
    mn = r_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    d_m = d_s[CW] ? (~d_s + 1'b1) : d_s;
  end

  // Hue from sector base and quotient, folded into 0..359.
  always_comb begin
    unique case (sec_q)
      SEC_G:   base_w = HW1'(HUE_120);
      SEC_B:   base_w = HW1'(HUE_240);
      default: base_w = '0;
    endcase
    q_w = {1'b0, qh_q};
    if (!neg_q) h_w = base_w + q_w;
    else if (base_w >= q_w) h_w = base_w - q_w;
    else h_w = base_w + HW1'(HUE_360) - q_w;
    if (h_w == HW1'(HUE_360)) h_w = '0;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    max_d     = max_q;
    c_d       = c_q;
    sec_d     = sec_q;
    neg_d     = neg_q;
    hinv_d    = hinv_q;
    qh_d      = qh_q;
    hue_d     = hue_q;
    sat_d     = sat_q;
    val_d     = val_q;
    hio_d     = hio_q;
    ov_d      = ov_q;
`ifdef RGB2HSV_SAT_NORM_EN
    qs_d      = qs_q;
`endif
    div_start = 1'b0;
    div_numer = '0;
    div_denom = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !div_busy) begin
          r_d     = in_rgb[3*CW-1:2*CW];
          g_d     = in_rgb[2*CW-1:CW];
          b_d     = in_rgb[CW-1:0];
          state_d = SORT;
        end
      end
      SORT: begin
        max_d  = mx;
        c_d    = mx - mn;
        sec_d  = sec;
        neg_d  = d_s[CW];
        hinv_d = (mx == mn);
        qh_d   = '0;
`ifdef RGB2HSV_SAT_NORM_EN
        qs_d   = '0;
`endif
        if (mx == mn) begin
          state_d = HUE;
        end else begin
          div_start = 1'b1;
          div_numer = DIV_W'(d_m[CW-1:0])
                    * DIV_W'(HUE_60);
          div_denom = DIV_W'(mx - mn);
          state_d   = DIV_H;
        end
      end
      DIV_H: begin
        if (div_done) begin
          qh_d = div_quot[HUE_W-1:0];
`ifdef RGB2HSV_SAT_NORM_EN
          div_start = 1'b1;
          div_numer = DIV_W'(c_q)
                    * DIV_W'((1 << CW) - 1);
          div_denom = DIV_W'(max_q);
          state_d   = DIV_S;
`else
          state_d = HUE;
`endif
        end
      end
`ifdef RGB2HSV_SAT_NORM_EN
      DIV_S: begin
        if (div_done) begin
          qs_d    = div_quot[CW-1:0];
          state_d = HUE;
        end
      end
`endif
      HUE: begin
        hue_d   = hinv_q ? '0 : h_w[HUE_W-1:0];
        val_d   = max_q;
`ifdef RGB2HSV_SAT_NORM_EN
        sat_d   = hinv_q ? '0 : qs_q;
`else
        sat_d   = c_q;
`endif
        hio_d   = hinv_q;
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ir_d = (state_d == IDLE);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      max_q   <= '0;
      c_q     <= '0;
      sec_q   <= SEC_R;
      neg_q   <= 1'b0;
      hinv_q  <= 1'b0;
      qh_q    <= '0;
      hue_q   <= '0;
      sat_q   <= '0;
      val_q   <= '0;
      hio_q   <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
`ifdef RGB2HSV_SAT_NORM_EN
      qs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      max_q   <= max_d;
      c_q     <= c_d;
      sec_q   <= sec_d;
      neg_q   <= neg_d;
      hinv_q  <= hinv_d;
      qh_q    <= qh_d;
      hue_q   <= hue_d;
      sat_q   <= sat_d;
      val_q   <= val_d;
      hio_q   <= hio_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
`ifdef RGB2HSV_SAT_NORM_EN
      qs_q    <= qs_d;
`endif
    end
  end

  assign in_ready    = ir_q;
  assign out_valid   = ov_q;
  assign hue         = hue_q;
  assign saturation  = sat_q;
  assign value       = val_q;
  assign hue_invalid = hio_q;

  assign unused_top = ^{div_quot[DIV_W-1:HUE_W],
                        h_w[HUE_W]};

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Directed bench for rgb2hsv_stream (CW=5).
// Expectations follow RGB2HSV_SAT_NORM_EN when defined.
module tb_rgb2hsv_stream;

  localparam int CW    = 5;
  localparam int HUE_W = 9;
`ifdef RGB2HSV_SAT_NORM_EN
  localparam int LAT  = 34;
  localparam bit NORM = 1'b1;
`else
  localparam int LAT  = 18;
  localparam bit NORM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             res_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3*CW-1:0]  in_rgb = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [HUE_W-1:0] hue;
  logic [CW-1:0]    saturation;
  logic [CW-1:0]    value;
  logic             hue_invalid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rgb2hsv_stream #(
    .CW(CW),
    .HUE_W(HUE_W)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hue        (hue),
    .saturation (saturation),
    .value      (value),
    .hue_invalid(hue_invalid)
  );

  function automatic logic [3*CW-1:0] pk(int r, int g, int b);
    return {CW'(r), CW'(g), CW'(b)};
  endfunction

  task automatic test_reset();
    #2 res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || hue !== '0 ||
        saturation !== '0 || value !== '0 ||
        hue_invalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs got v=%b h=%0d s=%0d val=%0d hi=%b want all 0",
               out_valid, hue, saturation, value, hue_invalid);
    end
    res_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic run_pixel(input string nm,
                           input int r, input int g, input int b,
                           input int eh, input int es_raw,
                           input int es_norm, input int ev,
                           input bit ehi, input int elat);
    int n;
    int es;
    bit got;
    es = NORM ? es_norm : es_raw;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_rgb   = pk(r, g, b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    n_cmp++;
    if (!got || n != elat) begin
      n_bad++;
      $display("FAIL %s latency got %0d (valid=%b) want %0d",
               nm, n, got, elat);
    end
    n_cmp++;
    if (hue !== HUE_W'(eh) || hue_invalid !== ehi) begin
      n_bad++;
      $display("FAIL %s hue got %0d/%b want %0d/%b",
               nm, hue, hue_invalid, eh, ehi);
    end
    n_cmp++;
    if (saturation !== CW'(es) || value !== CW'(ev)) begin
      n_bad++;
      $display("FAIL %s sat/val got %0d/%0d want %0d/%0d",
               nm, saturation, value, es, ev);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release got v=%b rdy=%b want 0/1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_primaries();
    run_pixel("red", 31, 0, 0, 0, 31, 31, 31, 0, LAT);
    run_pixel("orange", 31, 16, 0, 30, 31, 31, 31, 0, LAT);
    run_pixel("green", 0, 31, 0, 120, 31, 31, 31, 0, LAT);
    run_pixel("blue", 0, 0, 31, 240, 31, 31, 31, 0, LAT);
    run_pixel("rg_tie", 31, 31, 0, 60, 31, 31, 31, 0, LAT);
  endtask

  task automatic test_partial();
    run_pixel("r_mix", 20, 10, 5, 20, 15, 23, 20, 0, LAT);
    run_pixel("g_mix", 5, 20, 10, 140, 15, 23, 20, 0, LAT);
    run_pixel("b_mix", 10, 20, 25, 200, 15, 18, 25, 0, LAT);
  endtask

  task automatic test_neg_wrap();
    run_pixel("r_neg", 31, 0, 16, 330, 31, 31, 31, 0, LAT);
    run_pixel("rb_tie", 31, 0, 31, 300, 31, 31, 31, 0, LAT);
    run_pixel("g_neg", 16, 31, 0, 90, 31, 31, 31, 0, LAT);
    run_pixel("b_neg", 0, 16, 31, 210, 31, 31, 31, 0, LAT);
  endtask

  task automatic test_grey();
    run_pixel("grey", 10, 10, 10, 0, 0, 0, 10, 1, 2);
    run_pixel("black", 0, 0, 0, 0, 0, 0, 0, 1, 2);
    run_pixel("white", 31, 31, 31, 0, 0, 0, 31, 1, 2);
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    bit got;
    in_rgb   = pk(31, 16, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL bp_first got no out_valid after %0d", n);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_rgb   = pk(0, 0, 31);
        in_valid = 1'b1;
      end
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          hue !== 9'd30 || value !== 5'd31 ||
          saturation !== 5'd31 || hue_invalid !== 1'b0)
        bad++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    in_rgb    = pk(0, 31, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_handshake got rdy=%b v=%b want 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept got rdy=%b want 0", in_ready);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    n_cmp++;
    if (!got || n != LAT || hue !== 9'd120) begin
      n_bad++;
      $display("FAIL bp_next got lat=%0d hue=%0d want %0d/120",
               n, hue, LAT);
    end
  endtask

  task automatic test_reset_mid();
    // previous result (hue 120) still held, not yet released
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_rgb   = pk(31, 0, 16);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || hue !== '0 ||
        value !== '0 || saturation !== '0 ||
        hue_invalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async got v=%b h=%0d val=%0d s=%0d",
               out_valid, hue, value, saturation);
    end
    @(posedge clk);
    #1;
    res_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_release got rdy=%b v=%b want 1/0",
               in_ready, out_valid);
    end
    run_pixel("after_rst", 31, 0, 16, 330, 31, 31, 31, 0, LAT);
  endtask

  initial begin
    test_reset();
    test_primaries();
    test_partial();
    test_neg_wrap();
    test_grey();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb2hsv_stream.md
Name: rgb2hsv_stream

Overview:
- Parametrised successor to the camera-path RGB→HSV converter, between the pixel unpacker and the ball-colour classifier.
- Accepts one packed RGB pixel per valid/ready handshake and computes a full 0..359° hue, value and saturation.
- Uses a shared bit-serial restoring divider. Output is held until the consumer accepts it.
- One pixel in flight at a time; the block is not pipelined.

Parameters:
- CW, 5: channel width in bits for each of R, G, B.
- HUE_W, 9: hue output width. Must hold 359; minimum 9.
- DIV_W, 2*CW+6: divider numerator width, which is also the iteration count. Derived localparam; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- res_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel present on in_rgb.
- in_ready  out  1  block can accept a pixel; high only in IDLE.
- in_rgb  in  3*CW  packed {r, g, b}, with r in the MSBs.
- out_valid  out  1  result registers hold a valid pixel.
- out_ready  in  1  consumer accepts the result.
- hue  out  HUE_W  hue in degrees, 0..359.
- saturation  out  CW  saturation; see Optional Feature.
- value  out  CW  max(r, g, b).
- hue_invalid  out  1  chroma is 0 (grey); hue is forced to 0.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - out_valid, hue, saturation, value and hue_invalid are all 0.
  - in_ready is 1 after reset is released.
  - The divider is cleared.
  - Reset asserted mid-operation aborts the pixel and produces no output.
- IDLE: in_ready=1. When in_valid is high, latch r, g, b and go to SORT.
- SORT, 1 cycle:
  - max and min are selected with tie priority R>G>B. C = max-min.
  - Sector selection by max channel:
    - max R: d = g-b, base = 0.
    - max G: d = b-r, base = 120.
    - max B: d = r-g, base = 240.
  - The sign of d is latched.
  - If C==0: go to HUE with hue_invalid=1.
  - Otherwise: load the divider with numerator 60*|d| zero-extended to DIV_W, denominator C, and go to DIV_H.
- DIV_H: DIV_W cycles, one quotient bit per cycle, giving q = floor(60*|d|/C), with 0 ≤ q ≤ 60.
- HUE, 1 cycle:
  - If d ≥ 0: h = base+q.
  - If d < 0: h = base−q; if that is negative, add 360.
  - If h==360, h=0.
  - If hue_invalid: h=0.
  - Register hue, value=max, saturation, hue_invalid. Set out_valid=1 and go to OUT.
- OUT:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, go to IDLE.
  - The next pixel can be accepted on the cycle after the handshake.
- Latency, from the input handshake edge to out_valid:
  - C≠0: DIV_W+2 cycles (18 for CW=5).
  - C==0: 2 cycles.
- Throughput: at most one pixel per latency+2 cycles.
- in_valid may drop at any time while in_ready=0 without effect.
- Arithmetic is unsigned. |d| ≤ 2^CW−1, so 60*|d| fits in CW+6 bits.

Optional Feature:
- Macro: RGB2HSV_SAT_NORM_EN.
- Without the macro: saturation = C (raw chroma). FSM is as above.
- With the macro:
  - After DIV_H, an extra DIV_S state reuses the divider for DIV_W cycles.
  - It computes saturation = floor(C*(2^CW−1)/max); max==0 gives 0.
  - Latency with C≠0 becomes 2*DIV_W+2.
  - The C==0 path is unchanged: saturation=0, latency 2.
- hue and value are identical in both builds.

Decomposition:
- Package rgb2hsv_pkg holds:
  - FSM state enum: IDLE, SORT, DIV_H, DIV_S, HUE, OUT.
  - Sector enum: SEC_R, SEC_G, SEC_B.
  - Constants: HUE_60=60, HUE_120=120, HUE_240=240, HUE_360=360.
- One sub-module, seq_divider, parametrised by DIV_W:
  - Ports: start, numer, denom, busy, done, quot.
  - Fixed DIV_W-cycle restoring division, with an asynchronous active-low reset.

Test Plan (CW=5):
- Red (31,0,0) → hue 0, value 31, sat 31 (31 with NORM), hue_invalid 0, out_valid exactly 18 cycles after accept.
- (31,16,0) → 960/31 gives hue 30. (0,31,0) → hue 120. (0,0,31) → hue 240.
- Negative wrap, (31,0,16): d=−16, q=30 → hue 330. (31,0,31): R wins the tie, q=60, 0−60+360 → hue 300.
- Grey (10,10,10) → hue_invalid 1, hue 0, sat 0, value 10, latency 2. Black (0,0,0) → value 0, sat 0.
- Backpressure: hold out_ready=0 for 20 cycles → outputs stable, in_ready=0, a second in_valid is ignored. Then out_ready=1 → next pixel accepted the following cycle.
- Drop res_n mid-DIV_H → out_valid=0 and all outputs 0 asynchronously. After release, in_ready=1 and the next pixel's result is correct.
